// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and an
// optional first-word-fall-through read mode.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// leave it undefined for registered (one-cycle latency) reads.
module sync_fifo_flex #(
  parameter int DATA_LEN      = 16,
  parameter int ADDR_LEN      = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_LEN) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_LEN-1:0] i_data_in,
  input  logic                i_wrt_en,
  output logic                o_wrt_full,
  output logic                o_wrt_almost_full,
  input  logic                i_rd_en,
  output logic [DATA_LEN-1:0] o_data_out,
  output logic                o_rd_valid,
  output logic                o_rd_empty,
  output logic                o_rd_almost_empty,
  output logic [ADDR_LEN:0]   o_count,
  output logic                o_overflow,
  output logic                o_underflow,
  input  logic                i_clr_err
);

  localparam int FIFO_DEPTH = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] AFULL_T  = AFULL_THRESH[ADDR_LEN:0];
  localparam logic [ADDR_LEN:0] AEMPTY_T = AEMPTY_THRESH[ADDR_LEN:0];

  // Threshold sanity: an out-of-range threshold would make the flag meaningless.
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..FIFO_DEPTH-1");
  end

  // Storage and pointers. Pointers carry one extra wrap bit so full and
  // empty can be told apart when the low address bits match.
  logic [DATA_LEN-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_LEN:0]   r_wptr;
  logic [ADDR_LEN:0]   r_rptr;
  logic                r_overflow;
  logic                r_underflow;

  logic [ADDR_LEN:0]   w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [ADDR_LEN-1:0] w_waddr;
  logic [ADDR_LEN-1:0] w_raddr;

  // Status is decoded from registered pointers only, never from inputs.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_LEN] != r_rptr[ADDR_LEN]) &&
                   (r_wptr[ADDR_LEN-1:0] == r_rptr[ADDR_LEN-1:0]);
  assign w_waddr = r_wptr[ADDR_LEN-1:0];
  assign w_raddr = r_rptr[ADDR_LEN-1:0];

  // A write at full is rejected even if a read frees a slot the same cycle;
  // a read at empty is rejected even if a write lands the same cycle.
  assign w_wr_acc = i_wrt_en & ~w_full;
  assign w_rd_acc = i_rd_en & ~w_empty;

  assign o_count           = w_count;
  assign o_wrt_full        = w_full;
  assign o_rd_empty        = w_empty;
  assign o_wrt_almost_full = (w_count >= AFULL_T);
  assign o_rd_almost_empty = (w_count <= AEMPTY_T);
  assign o_overflow        = r_overflow;
  assign o_underflow       = r_underflow;

  // Advance write/read pointers on accepted transfers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Memory write port; contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[w_waddr] <= i_data_in;
  end

  // Sticky error flags: a new error in the same cycle beats clr_err.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_wrt_en & w_full)  | (r_overflow  & ~i_clr_err);
      r_underflow <= (i_rd_en  & w_empty) | (r_underflow & ~i_clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so the output
  // never exposes stale memory after reset.
  assign o_data_out = w_empty ? '0 : r_mem[w_raddr];
  assign o_rd_valid = ~w_empty;
`else
  logic [DATA_LEN-1:0] r_data_out;
  logic                r_rd_valid;

  // Registered read: popped word appears the cycle after the accepted read,
  // and data_out holds its value when no read is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_data_out <= r_mem[w_raddr];
    end
  end

  assign o_data_out = r_data_out;
  assign o_rd_valid = r_rd_valid;
`endif

endmodule
